// File: rtl/uart_tx_word_pkg.sv
// Shared constants for the word-oriented UART transmit path.
// The receive side uses the same bit period and word width.
package uart_tx_word_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int WORD_WIDTH        = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous word FIFO with first-word-fall-through read.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module uart_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped; the stored words are never overwritten.
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_word.sv
// Word transmitter: queues 16-bit words and sends each as two 8N1 frames,
// low byte first, so the receive-side assembler rebuilds the same word.
module uart_tx_word
    import uart_tx_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           words_sent
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             byte_sel;
    word_t            shift;
    word_t            fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             bit_end;
    logic             tx_next;

    uart_tx_fifo #(
        .WIDTH(WORD_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (MAX10_CLK1_50),
        .rst  (rst),
        .push (word_valid),
        .pop  (fifo_pop),
        .din  (word_in),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Pop either from idle or straight out of the final stop bit, so
    // queued words follow each other with no gap on the line.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                fifo_pop = 1'b1;
            end else if (state == STOP && bit_end && byte_sel) begin
                fifo_pop = 1'b1;
            end
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_sel   <= 1'b0;
            words_sent <= 16'd0;
            tx         <= 1'b1;
        end else begin
            tx <= tx_next;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        byte_sel <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= START;
                        end else begin
                            words_sent <= words_sent + 16'd1;
                            if (fifo_pop) begin
                                byte_sel <= 1'b0;
                                state    <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // After eight data shifts the high byte sits in the low bits, ready
    // for the second frame.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (fifo_pop) begin
            shift <= fifo_dout;
        end else if (state == DATA && bit_end) begin
            shift <= shift >> 1;
        end
    end

    assign word_ready = ~fifo_full;
    assign busy       = (state != IDLE) | ~fifo_empty;

endmodule
